// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared widths and result entry type for the sqrt result path
package sqrt_pkg;

  localparam int DEF_ROOT_WIDTH = 8;
  localparam int DEF_SEQ_WIDTH  = 4;
  localparam int DEF_DEPTH      = 4;

  // One buffered completion: the finished root and its sequence tag
  typedef struct packed {
    logic [DEF_ROOT_WIDTH-1:0] root;
    logic [DEF_SEQ_WIDTH-1:0]  seq;
  } entry_t;

endpackage

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock first-word-fall-through FIFO with level count
module fifo_sync #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  // Pointer and level update; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array, deliberately not reset; reads are gated by level instead
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/sqrt_result_buffer.sv
// rtl/sqrt_result_buffer.sv - captures, tags and buffers square-root completions
module sqrt_result_buffer
  import sqrt_pkg::*;
#(
  parameter int ROOT_WIDTH = DEF_ROOT_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int SEQ_WIDTH  = DEF_SEQ_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ROOT_WIDTH-1:0]    root_i,
  input  logic                     done_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [ROOT_WIDTH-1:0]    res_root_o,
  output logic [SEQ_WIDTH-1:0]     res_seq_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  input  logic                     clr_ovf_i
);

  localparam int EW = ROOT_WIDTH + SEQ_WIDTH;

  logic                 done_q;
  logic [SEQ_WIDTH-1:0] seq_q, seq_d;
  logic                 ovf_q, ovf_d;
  logic                 cap, pop, push, drop;
  logic                 fifo_full, fifo_empty;
  logic [EW-1:0]        head;

  // A completion is a 0->1 edge of done_i; full FIFO accepts only alongside a pop
  always_comb begin
    cap  = done_i & ~done_q;
    pop  = ~fifo_empty & res_ready_i;
    push = cap & (~fifo_full | pop);
    drop = cap & fifo_full & ~pop;
  end

  // Tag counter advances on every completion so dropped results leave a visible gap;
  // a drop in the same cycle as a clear keeps the overflow flag set
  always_comb begin
    seq_d = cap ? seq_q + SEQ_WIDTH'(1) : seq_q;
    ovf_d = ovf_q;
    if (clr_ovf_i) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
  end

  // Edge detector resets high so a done_i already asserted at release is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b1;
      seq_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= done_i;
      seq_q  <= seq_d;
      ovf_q  <= ovf_d;
    end
  end

  fifo_sync #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({root_i, seq_q}),
    .rdata_o (head),
    .level_o (level_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign res_valid_o = ~fifo_empty;
  assign res_root_o  = head[EW-1:SEQ_WIDTH];
  assign res_seq_o   = head[SEQ_WIDTH-1:0];
  assign full_o      = fifo_full;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_sqrt_result_buffer.sv
// tb/tb_sqrt_result_buffer.sv - vector table, corner sequences and random run against a queue model
module tb_sqrt_result_buffer;
  import sqrt_pkg::*;

  localparam int RW = 8;
  localparam int SW = 4;
  localparam int D  = 4;

  logic          clk;
  logic          rst_n;
  logic [RW-1:0] root_i;
  logic          done_i;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [RW-1:0] res_root_o;
  logic [SW-1:0] res_seq_o;
  logic          full_o;
  logic [2:0]    level_o;
  logic          overflow_o;
  logic          clr_ovf_i;

  int n_cmp  = 0;
  int n_fail = 0;

  sqrt_result_buffer #(.ROOT_WIDTH(RW), .DEPTH(D), .SEQ_WIDTH(SW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .root_i      (root_i),
    .done_i      (done_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_root_o  (res_root_o),
    .res_seq_o   (res_seq_o),
    .full_o      (full_o),
    .level_o     (level_o),
    .overflow_o  (overflow_o),
    .clr_ovf_i   (clr_ovf_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of tagged results plus last done level, tag counter, sticky flag
  entry_t mq[$];
  logic   m_last_done;
  int     m_seq;
  logic   m_ovf;

  task automatic model_reset();
    mq.delete();
    m_last_done = 1'b1;
    m_seq       = 0;
    m_ovf       = 1'b0;
  endtask

  task automatic model_step(input logic d, input logic r, input logic [RW-1:0] rt, input logic c);
    entry_t e;
    bit cap, do_pop, dropped;
    cap     = d && !m_last_done;
    do_pop  = (mq.size() != 0) && r;
    dropped = 1'b0;
    if (do_pop) void'(mq.pop_front());
    if (cap) begin
      if (mq.size() < D) begin
        e.root = rt;
        e.seq  = m_seq[SW-1:0];
        mq.push_back(e);
      end else begin
        dropped = 1'b1;
      end
      m_seq = (m_seq + 1) % (1 << SW);
    end
    if (dropped)  m_ovf = 1'b1;
    else if (c)   m_ovf = 1'b0;
    m_last_done = d;
  endtask

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    int ev, er, es;
    ev = (mq.size() != 0) ? 1 : 0;
    er = ev ? int'(mq[0].root) : 0;
    es = ev ? int'(mq[0].seq) : 0;
    cmp({tag, "_valid"}, int'(res_valid_o), ev);
    cmp({tag, "_root"},  int'(res_root_o), er);
    cmp({tag, "_seq"},   int'(res_seq_o), es);
    cmp({tag, "_level"}, int'(level_o), mq.size());
    cmp({tag, "_full"},  int'(full_o), (mq.size() == D) ? 1 : 0);
    cmp({tag, "_ovf"},   int'(overflow_o), int'(m_ovf));
  endtask

  // One clock: drive inputs, advance the model, then sample 1 time unit after the edge
  task automatic cyc(input logic d, input logic r, input logic [RW-1:0] rt, input logic c);
    done_i      = d;
    res_ready_i = r;
    root_i      = rt;
    clr_ovf_i   = c;
    model_step(d, r, rt, c);
    @(posedge clk);
    #1;
    check_model("model");
  endtask

  task automatic do_reset(input logic d);
    rst_n       = 1'b0;
    done_i      = d;
    res_ready_i = 1'b0;
    clr_ovf_i   = 1'b0;
    root_i      = '0;
    #1;
    model_reset();
    check_model("reset");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic          done;
    logic          ready;
    logic [RW-1:0] root;
    logic          clr;
    logic          ev;
    logic [RW-1:0] er;
    logic [SW-1:0] es;
    logic [2:0]    el;
    logic          ef;
    logic          eo;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic d, input logic r, input logic [RW-1:0] rt, input logic c,
                              input logic ev, input logic [RW-1:0] er, input logic [SW-1:0] es,
                              input logic [2:0] el, input logic ef, input logic eo);
    vec_t v;
    v.done = d;  v.ready = r; v.root = rt; v.clr = c;
    v.ev = ev;   v.er = er;   v.es = es;   v.el = el; v.ef = ef; v.eo = eo;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; done_i = 1'b0; res_ready_i = 1'b0; root_i = '0; clr_ovf_i = 1'b0;
    model_reset();

    // Vectors: done held high across reset, single capture/pop, level-high done gives one entry
    tbl[0]  = mk(1, 0, 8'd0,  0, 0, 8'd0,  4'd0, 3'd0, 0, 0);
    tbl[1]  = mk(1, 1, 8'd3,  0, 0, 8'd0,  4'd0, 3'd0, 0, 0);
    tbl[2]  = mk(0, 1, 8'd0,  0, 0, 8'd0,  4'd0, 3'd0, 0, 0);
    tbl[3]  = mk(1, 1, 8'd15, 0, 1, 8'd15, 4'd0, 3'd1, 0, 0);
    tbl[4]  = mk(1, 1, 8'd15, 0, 0, 8'd0,  4'd0, 3'd0, 0, 0);
    tbl[5]  = mk(0, 0, 8'd0,  0, 0, 8'd0,  4'd0, 3'd0, 0, 0);
    tbl[6]  = mk(1, 0, 8'd7,  0, 1, 8'd7,  4'd1, 3'd1, 0, 0);
    for (int i = 7; i <= 15; i++) tbl[i] = mk(1, 0, 8'd9, 0, 1, 8'd7, 4'd1, 3'd1, 0, 0);
    tbl[16] = mk(0, 1, 8'd0,  0, 0, 8'd0,  4'd0, 3'd0, 0, 0);
    tbl[17] = mk(1, 0, 8'd33, 0, 1, 8'd33, 4'd2, 3'd1, 0, 0);
    tbl[18] = mk(0, 1, 8'd0,  0, 0, 8'd0,  4'd0, 3'd0, 0, 0);

    do_reset(1'b1);
    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].done, tbl[i].ready, tbl[i].root, tbl[i].clr);
      cmp($sformatf("tbl%0d_valid", i), int'(res_valid_o), int'(tbl[i].ev));
      cmp($sformatf("tbl%0d_root", i),  int'(res_root_o),  int'(tbl[i].er));
      cmp($sformatf("tbl%0d_seq", i),   int'(res_seq_o),   int'(tbl[i].es));
      cmp($sformatf("tbl%0d_level", i), int'(level_o),     int'(tbl[i].el));
      cmp($sformatf("tbl%0d_full", i),  int'(full_o),      int'(tbl[i].ef));
      cmp($sformatf("tbl%0d_ovf", i),   int'(overflow_o),  int'(tbl[i].eo));
    end

    // Fill with consumer stalled, fifth completion is dropped
    do_reset(1'b0);
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 0, 8'd0, 0);
      cyc(1, 0, RW'(k), 0);
      if (k == 3) cmp("t4_notfull3", int'(full_o), 0);
      if (k == 4) cmp("t4_full4", int'(full_o), 1);
    end
    cmp("t4_ovf", int'(overflow_o), 1);
    cmp("t4_level", int'(level_o), 4);
    for (int k = 1; k <= 4; k++) begin
      cmp($sformatf("t4_drain_root%0d", k), int'(res_root_o), k);
      cmp($sformatf("t4_drain_seq%0d", k), int'(res_seq_o), k - 1);
      cyc(0, 1, 8'd0, 0);
    end
    cmp("t4_empty", int'(res_valid_o), 0);
    cyc(0, 0, 8'd0, 0);
    cyc(1, 0, 8'd99, 0);
    cmp("t4_gap_seq", int'(res_seq_o), 5);
    cyc(0, 1, 8'd0, 0);

    // Full FIFO with completion and pop together: no drop
    cyc(0, 0, 8'd0, 1);
    cmp("t6_clear_alone", int'(overflow_o), 0);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 8'd0, 0);
      cyc(1, 0, RW'(10 + k), 0);
    end
    cyc(0, 0, 8'd0, 0);
    cyc(1, 1, 8'd50, 0);
    cmp("t5_level", int'(level_o), 4);
    cmp("t5_ovf", int'(overflow_o), 0);
    cmp("t5_head", int'(res_root_o), 12);

    // Drop sets overflow; clear coinciding with a drop loses; clear alone wins
    cyc(0, 0, 8'd0, 0);
    cyc(1, 0, 8'd60, 0);
    cmp("t6_drop", int'(overflow_o), 1);
    cyc(0, 0, 8'd0, 0);
    cyc(1, 0, 8'd61, 1);
    cmp("t6_drop_beats_clr", int'(overflow_o), 1);
    cyc(0, 0, 8'd0, 1);
    cmp("t6_clr", int'(overflow_o), 0);

    // Sequence tag wraps after 16 completions
    do_reset(1'b0);
    for (int k = 0; k < 17; k++) begin
      cyc(0, 1, 8'd0, 0);
      cyc(1, 1, RW'(k + 100), 0);
      cmp($sformatf("t7_seq%0d", k), int'(res_seq_o), k % 16);
      cmp($sformatf("t7_root%0d", k), int'(res_root_o), k + 100);
    end
    cyc(0, 1, 8'd0, 0);

    // Random traffic including one reset in the middle
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset($urandom_range(0, 1) == 1);
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, RW'($urandom),
          $urandom_range(0, 15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
